outputconditioner: RTL

OUTPUTCONDITIONER -- requirements
Module: outputconditioner

---
 rtl/outputconditioner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/outputconditioner.sv
// Purpose: debounced/dwell-limited level output driven by set/clear requests, with edge and conflict pulses.
// Latency: one clock from a sampled request to sigout/busy/edge outputs; all outputs registered.
// Backpressure: none; requests arriving during a dwell collapse into one pending flag (latest wins).
module outputconditioner #(
   parameter int counterwidth = 3,
   parameter int holdtime     = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic setreq,
   input  logic clrreq,
   output logic sigout,
   output logic busy,
   output logic positiveedge,
   output logic negativeedge,
   output logic conflict
);

   typedef enum logic [1:0] {
      STABLELOW  = 2'd0,
      HOLDHIGH   = 2'd1,
      STABLEHIGH = 2'd2,
      HOLDLOW    = 2'd3
   } state_t;

   localparam logic [counterwidth-1:0] CNT_LAST = counterwidth'(holdtime);
   localparam logic [counterwidth-1:0] CNT_ONE  = counterwidth'(1);
   localparam logic [counterwidth-1:0] CNT_ZERO = '0;

   state_t                  state_q, state_d;
   logic [counterwidth-1:0] cnt_q, cnt_d;
   logic                    pend_q, pend_d;
   logic                    sigout_q, sigout_d;
   logic                    busy_q, busy_d;
   logic                    pos_q, pos_d;
   logic                    neg_q, neg_d;
   logic                    conf_q, conf_d;

   logic set_only, clr_only, pend_n;

   assign set_only = setreq & ~clrreq;
   assign clr_only = clrreq & ~setreq;

   // FSM state, dwell counter and pending flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= STABLELOW;
         cnt_q   <= CNT_ZERO;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state logic: request handling, dwell counting and hold expiry
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      pend_n  = pend_q;
      case (state_q)
         STABLELOW: begin
            if (set_only) begin
               state_d = HOLDHIGH;
               cnt_d   = CNT_ZERO;
               pend_d  = 1'b0;
            end
         end
         STABLEHIGH: begin
            if (clr_only) begin
               state_d = HOLDLOW;
               cnt_d   = CNT_ZERO;
               pend_d  = 1'b0;
            end
         end
         HOLDHIGH, HOLDLOW: begin
            // A request opposite to the held level arms the flag, an equal one disarms it.
            if (state_q == HOLDHIGH) begin
               if (clr_only)      pend_n = 1'b1;
               else if (set_only) pend_n = 1'b0;
            end else begin
               if (set_only)      pend_n = 1'b1;
               else if (clr_only) pend_n = 1'b0;
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d  = CNT_ZERO;
               pend_d = 1'b0;
               if (pend_n) state_d = (state_q == HOLDHIGH) ? HOLDLOW : HOLDHIGH;
               else        state_d = (state_q == HOLDHIGH) ? STABLEHIGH : STABLELOW;
            end else begin
               cnt_d  = cnt_q + CNT_ONE;
               pend_d = pend_n;
            end
         end
         default: begin
            state_d = STABLELOW;
            cnt_d   = CNT_ZERO;
            pend_d  = 1'b0;
         end
      endcase
   end

   // Output decode from the upcoming state; edges fire only when the level actually flips
   always_comb begin
      sigout_d = (state_d == HOLDHIGH) || (state_d == STABLEHIGH);
      busy_d   = (state_d == HOLDHIGH) || (state_d == HOLDLOW);
      pos_d    = (state_d == HOLDHIGH) && (state_q != HOLDHIGH) && (state_q != STABLEHIGH);
      neg_d    = (state_d == HOLDLOW) && (state_q != HOLDLOW) && (state_q != STABLELOW);
      conf_d   = setreq & clrreq;
   end

   // Registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sigout_q <= 1'b0;
         busy_q   <= 1'b0;
         pos_q    <= 1'b0;
         neg_q    <= 1'b0;
         conf_q   <= 1'b0;
      end else begin
         sigout_q <= sigout_d;
         busy_q   <= busy_d;
         pos_q    <= pos_d;
         neg_q    <= neg_d;
         conf_q   <= conf_d;
      end
   end

   assign sigout       = sigout_q;
   assign busy         = busy_q;
   assign positiveedge = pos_q;
   assign negativeedge = neg_q;
   assign conflict     = conf_q;

endmodule
